// File: rtl/rf_pkg.sv
// Shared types and default widths for the multi-port register file.
package rf_pkg;

   typedef enum logic {
      RF_CLEAR,
      RF_RUN
   } rf_state_t;

   localparam int RF_DATA_W_DEF = 32;
   localparam int RF_ADDR_W_DEF = 5;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Reset/clear sequencer: sweeps every entry to zero after reset.
module rf_clear_ctrl
   import rf_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      busy     = (state_q == RF_CLEAR);
      clr_en   = 1'b0;
      clr_addr = ptr_q;
      unique case (state_q)
         RF_CLEAR: begin
            // No clear write in a cycle where reset is held
            clr_en = !rst;
            ptr_d  = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST) state_d = RF_RUN;
         end
         RF_RUN: state_d = RF_RUN;
      endcase
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD async reads, two prioritised writes,
// optional bypass and hardwired-zero entry 0.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W_DEF,
   parameter int ADDR_W   = RF_ADDR_W_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  wa_en,
   input  logic [ADDR_W-1:0]     wa_addr,
   input  logic [DATA_W-1:0]     wa_data,
   input  logic                  wb_en,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  busy,
   output logic                  wr_collide
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              same_addr;
   logic              wa_zero, wb_zero;
   logic              wa_we, wb_we;
   logic              coll_d, coll_q;

   rf_clear_ctrl #(
      .ADDR_W(ADDR_W)
   ) u_clr (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_addr(clr_addr)
   );

   assign same_addr = (wa_addr == wb_addr);
   assign wa_zero   = (ZERO_REG != 0) && (wa_addr == '0);
   assign wb_zero   = (ZERO_REG != 0) && (wb_addr == '0);

   // Port A wins an address clash; B is then dropped
   assign wa_we = wa_en && !busy && !rst && !wa_zero;
   assign wb_we = wb_en && !busy && !rst && !wb_zero
                  && !(wa_en && same_addr);

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem_q[clr_addr] <= '0;
      end else begin
         if (wa_we) mem_q[wa_addr] <= wa_data;
         if (wb_we) mem_q[wb_addr] <= wb_data;
      end
   end

   assign coll_d = wa_en && wb_en && same_addr && !busy;

   always_ff @(posedge clk) begin
      if (rst) coll_q <= 1'b0;
      else     coll_q <= coll_d;
   end

   assign wr_collide = coll_q;

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = raddr[g*ADDR_W +: ADDR_W];

      always_comb begin
         rd = mem_q[ra];
         if (busy)
            rd = '0;
         else if ((ZERO_REG != 0) && (ra == '0))
            rd = '0;
         else if ((BYPASS != 0) && wa_en && (wa_addr == ra))
            rd = wa_data;
         else if ((BYPASS != 0) && wb_en && (wb_addr == ra))
            rd = wb_data;
      end

      assign rdata[g*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations driven from one stimulus,
// checked every cycle against a behavioural register-file model.
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst     = 1'b1;
   logic          wa_en   = 1'b0;
   logic [AW-1:0] wa_addr = '0;
   logic [DW-1:0] wa_data = '0;
   logic          wb_en   = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;

   logic [2*AW-1:0] ra0 = '0;
   logic [4*AW-1:0] ra1 = '0;
   logic [2*DW-1:0] rd0;
   logic [4*DW-1:0] rd1;
   logic            busy0, busy1, col0, col1;

   int nchk = 0;
   int nerr = 0;

   reg_file_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(1), .BYPASS(1)
   ) dut0 (
      .clk(clk), .rst(rst), .raddr(ra0), .rdata(rd0),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy(busy0), .wr_collide(col0)
   );

   reg_file_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NRD(4), .ZERO_REG(0), .BYPASS(0)
   ) dut1 (
      .clk(clk), .rst(rst), .raddr(ra1), .rdata(rd1),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy(busy1), .wr_collide(col1)
   );

   // Behavioural model: contents, remaining sweep cycles, collision pulse
   logic [DW-1:0] m0 [DEPTH];
   logic [DW-1:0] m1 [DEPTH];
   int  left    = 0;
   bit  cexp    = 1'b0;
   bit  started = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         left    <= DEPTH;
         cexp    <= 1'b0;
         started <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            m0[i] <= '0;
            m1[i] <= '0;
         end
      end else if (left > 0) begin
         left <= left - 1;
         cexp <= 1'b0;
      end else begin
         cexp <= wa_en && wb_en && (wa_addr == wb_addr);
         if (wb_en) begin
            m0[wb_addr] <= wb_data;
            m1[wb_addr] <= wb_data;
         end
         if (wa_en) begin
            m0[wa_addr] <= wa_data;
            m1[wa_addr] <= wa_data;
         end
      end
   end

   function automatic logic [DW-1:0] exp_rd(input bit zr, input bit bp,
                                            input logic [AW-1:0] a,
                                            input bit sel1);
      if (left > 0) return '0;
      if (zr && a == 0) return '0;
      if (bp && wa_en && wa_addr == a) return wa_data;
      if (bp && wb_en && wb_addr == a) return wb_data;
      return sel1 ? m1[a] : m0[a];
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("busy0", {31'b0, busy0}, {31'b0, left > 0});
         chk("busy1", {31'b0, busy1}, {31'b0, left > 0});
         chk("coll0", {31'b0, col0}, {31'b0, cexp});
         chk("coll1", {31'b0, col1}, {31'b0, cexp});
         for (int i = 0; i < 2; i++)
            chk("rd0", rd0[i*DW +: DW], exp_rd(1, 1, ra0[i*AW +: AW], 0));
         for (int i = 0; i < 4; i++)
            chk("rd1", rd1[i*DW +: DW], exp_rd(0, 0, ra1[i*AW +: AW], 1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en = 1'b0;
      wb_en = 1'b0;
   endtask

   task automatic wait_sweep(input string nm);
      int n;
      n = 0;
      while (busy0 && n < 100) begin
         step();
         n++;
      end
      chk(nm, n, 32);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      rst = 1'b0;
      wait_sweep("busy_len_reset");

      for (int i = 0; i < DEPTH; i++) begin
         ra0 = {2{AW'(i)}};
         ra1 = {4{AW'(i)}};
         #2;
         chk("clear_rd0", rd0[DW-1:0], 0);
         chk("clear_rd1", rd1[2*DW-1:DW], 0);
         step();
      end

      // Bypass vs registered visibility
      wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
      ra0 = {2{AW'(5)}}; ra1 = {4{AW'(5)}};
      #2;
      chk("bypass_same", rd0[DW-1:0], 32'hDEADBEEF);
      chk("nobypass_same", rd1[DW-1:0], 0);
      step(); idle(); #2;
      chk("nobypass_next", rd1[DW-1:0], 32'hDEADBEEF);
      step();

      // Same-address collision, A wins
      wa_en = 1; wa_addr = 7; wa_data = 32'h11;
      wb_en = 1; wb_addr = 7; wb_data = 32'h22;
      step(); idle();
      ra0 = {2{AW'(7)}}; ra1 = {4{AW'(7)}};
      #2;
      chk("collide_pulse", {31'b0, col0}, 1);
      chk("collide_rd", rd0[DW-1:0], 32'h11);
      step(); #2;
      chk("collide_end", {31'b0, col0}, 0);
      wa_en = 1; wa_addr = 7; wa_data = 32'h11;
      wb_en = 1; wb_addr = 8; wb_data = 32'h22;
      step(); idle();
      ra0 = {2{AW'(8)}}; ra1 = {4{AW'(8)}};
      #2;
      chk("nocollide", {31'b0, col0}, 0);
      chk("rd8", rd0[DW-1:0], 32'h22);
      step();

      // Entry 0
      wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
      ra0 = '0; ra1 = '0;
      #2;
      chk("zero_same", rd0[DW-1:0], 0);
      step(); idle(); #2;
      chk("zero_later", rd0[DW-1:0], 0);
      chk("nonzero_reg0", rd1[DW-1:0], 32'hFFFFFFFF);
      step();

      // Four independent ports plus a duplicate pair
      wa_en = 1; wa_addr = 10; wa_data = 32'hA0A0A0A0;
      wb_en = 1; wb_addr = 11; wb_data = 32'hB1B1B1B1;
      step();
      wa_addr = 12; wa_data = 32'hC2C2C2C2;
      wb_addr = 13; wb_data = 32'hD3D3D3D3;
      step(); idle();
      ra1 = {AW'(13), AW'(12), AW'(11), AW'(10)};
      #2;
      chk("p0", rd1[0*DW +: DW], 32'hA0A0A0A0);
      chk("p1", rd1[1*DW +: DW], 32'hB1B1B1B1);
      chk("p2", rd1[2*DW +: DW], 32'hC2C2C2C2);
      chk("p3", rd1[3*DW +: DW], 32'hD3D3D3D3);
      step();
      ra1 = {AW'(13), AW'(11), AW'(11), AW'(10)};
      #2;
      chk("dup_a", rd1[1*DW +: DW], 32'hB1B1B1B1);
      chk("dup_b", rd1[2*DW +: DW], rd1[1*DW +: DW]);
      step();

      // Reset mid-sweep with writes attempted throughout
      rst = 1'b1;
      step();
      rst = 1'b0;
      wa_en = 1;
      for (int i = 0; i < 10; i++) begin
         wa_addr = AW'($urandom);
         wa_data = $urandom;
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      wa_addr = 5; wa_data = 32'h12345678;
      wait_sweep("busy_len_restart");
      idle();
      ra0 = {AW'(7), AW'(5)};
      ra1 = {AW'(13), AW'(12), AW'(8), AW'(10)};
      #2;
      chk("restart_rd5", rd0[0*DW +: DW], 0);
      chk("restart_rd7", rd0[1*DW +: DW], 0);
      chk("restart_rd10", rd1[0*DW +: DW], 0);
      chk("restart_rd8", rd1[1*DW +: DW], 0);
      step();

      // Random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         rst     = ($urandom_range(0, 399) == 0);
         wa_en   = $urandom_range(0, 1) == 1;
         wb_en   = $urandom_range(0, 1) == 1;
         wa_addr = AW'($urandom);
         wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom);
         wa_data = $urandom;
         wb_data = $urandom;
         ra0     = 2*AW'($urandom);
         ra1     = 4*AW'($urandom);
         if ($urandom_range(0, 3) == 0) ra0[AW-1:0] = wa_addr;
         if ($urandom_range(0, 3) == 0) ra1[AW-1:0] = wb_addr;
         step();
      end
      rst = 1'b0;
      idle();
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
